pipeline_stall_controller: RTL

//  Consumes hazard requests (nop from hazard detection), EX-stage branch resolution and data-memory busy.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/pipeline_stall_controller_sat_counter.sv | 19 +
 rtl/pipeline_stall_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall controller: FSM state, control bundle
// and the "no hazard" request encoding.
package pipeline_pkg;

   typedef enum logic {RUN, STALL} stall_state_t;

   typedef struct packed {
      logic stall_pc;
      logic stall_fetch_decode;
      logic flush_fetch_decode;
      logic flush_decode_execute;
      logic freeze_all;
   } pipe_ctrl_t;

   localparam logic [1:0] NOP_NONE = 2'b00;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hold/flush sequencing for the pipeline register banks (Mealy, zero latency).
// Statistics counters exist only when PIPE_STALL_STATS_EN is defined.
//
//   state | meaning
//   RUN   | normal flow; a nop request inserts the first bubble
//   STALL | extra load-use bubbles pending, cnt = bubbles still to insert
module pipeline_stall_controller
   import pipeline_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       nop_request,
   input  logic             branch_taken_execute,
   input  logic             mem_busy,
   output logic             stall_pc,
   output logic             stall_fetch_decode,
   output logic             flush_fetch_decode,
   output logic             flush_decode_execute,
   output logic             freeze_all,
   output logic [CNT_W-1:0] stall_cycles_total,
   output logic [CNT_W-1:0] flush_events_total
);

   stall_state_t state, state_next;
   logic [3:0]   cnt, cnt_next;
   pipe_ctrl_t   ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      ctrl       = '0;
      state_next = state;
      cnt_next   = cnt;
      if (mem_busy) begin
         ctrl.freeze_all         = 1'b1;
         ctrl.stall_pc           = 1'b1;
         ctrl.stall_fetch_decode = 1'b1;
      end else if (branch_taken_execute) begin
         // The pending stall belongs to a wrong-path instruction, so drop it.
         ctrl.flush_fetch_decode   = 1'b1;
         ctrl.flush_decode_execute = 1'b1;
         state_next                = RUN;
         cnt_next                  = 4'd0;
      end else if ((state == STALL) || (nop_request != NOP_NONE)) begin
         ctrl.stall_pc             = 1'b1;
         ctrl.stall_fetch_decode   = 1'b1;
         ctrl.flush_decode_execute = 1'b1;
         if (state == STALL) begin
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_next = RUN;
            end
         end else if (STALL_CYCLES > 1) begin
            state_next = STALL;
            cnt_next   = 4'(STALL_CYCLES - 1);
         end
      end
      if (rst) begin
         ctrl = '0;
      end
   end

   assign stall_pc             = ctrl.stall_pc;
   assign stall_fetch_decode   = ctrl.stall_fetch_decode;
   assign flush_fetch_decode   = ctrl.flush_fetch_decode;
   assign flush_decode_execute = ctrl.flush_decode_execute;
   assign freeze_all           = ctrl.freeze_all;

`ifdef PIPE_STALL_STATS_EN
   logic stall_inc, flush_inc;

   // flush_fetch_decode is only ever raised by a taken branch.
   assign stall_inc = ctrl.stall_fetch_decode & ~ctrl.freeze_all;
   assign flush_inc = ctrl.flush_fetch_decode;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles_total)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_events_total)
   );
`else
   assign stall_cycles_total = '0;
   assign flush_events_total = '0;
`endif

endmodule
